// File: rtl/lcd_char_driver.sv
// Write-only HD44780-style 8-bit LCD driver: takes one byte write at a time from
// the CPU's LCD register and sequences setup, EN pulse, hold and execution delay.
module lcd_char_driver #(
  parameter int unsigned T_POWERUP = 750000,
  parameter int unsigned T_SETUP   = 2,
  parameter int unsigned T_PW      = 12,
  parameter int unsigned T_HOLD    = 2,
  parameter int unsigned T_EXEC    = 2000,
  parameter int unsigned T_CLEAR   = 82000,
  parameter int unsigned CNT_W     = 20
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       wr_valid_i,
  output logic       wr_ready_o,
  input  logic       wr_rs_i,
  input  logic [7:0] wr_data_i,
  input  logic       lcd_on_en_i,
  output logic       busy_o,
  output logic       lcd_on_o,
  output logic       lcd_en_o,
  output logic       lcd_rs_o,
  output logic       lcd_rw_o,
  output logic [7:0] lcd_data_o
);

  // A zero-length phase still occupies one cycle.
  function automatic int unsigned at_least_one(input int unsigned t);
    return (t == 0) ? 32'd1 : t;
  endfunction

  localparam logic [CNT_W-1:0] POWERUP_LAST = CNT_W'(at_least_one(T_POWERUP) - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST   = CNT_W'(at_least_one(T_SETUP) - 1);
  localparam logic [CNT_W-1:0] PW_LAST      = CNT_W'(at_least_one(T_PW) - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(at_least_one(T_HOLD) - 1);
  localparam logic [CNT_W-1:0] EXEC_LAST    = CNT_W'(at_least_one(T_EXEC) - 1);
  localparam logic [CNT_W-1:0] CLEAR_LAST   = CNT_W'(at_least_one(T_CLEAR) - 1);

  typedef enum logic [2:0] {
    ST_POWERUP = 3'd0,
    ST_IDLE    = 3'd1,
    ST_SETUP   = 3'd2,
    ST_PULSE   = 3'd3,
    ST_HOLD    = 3'd4,
    ST_EXEC    = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rs_q, rs_d;
  logic [7:0]       data_q, data_d;
  logic             en_q;
  logic             ready_q;
  logic             busy_q;
  logic             on_q;

  logic             accept;
  logic             long_exec;
  logic [CNT_W-1:0] exec_last;

  assign accept = wr_valid_i && ready_q;

  // Clear-display and return-home need the long execution time; data writes never do.
  assign long_exec = !rs_q && ((data_q == 8'h01) || (data_q == 8'h02) || (data_q == 8'h03));
  assign exec_last = long_exec ? CLEAR_LAST : EXEC_LAST;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    rs_d    = rs_q;
    data_d  = data_q;
    case (state_q)
      ST_POWERUP: begin
        if (cnt_q == POWERUP_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      ST_IDLE: begin
        cnt_d = '0;
        if (accept) begin
          state_d = ST_SETUP;
          rs_d    = wr_rs_i;
          data_d  = wr_data_i;
        end
      end
      ST_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = ST_PULSE;
          cnt_d   = '0;
        end
      end
      ST_PULSE: begin
        if (cnt_q == PW_LAST) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end
      end
      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = ST_EXEC;
          cnt_d   = '0;
        end
      end
      ST_EXEC: begin
        if (cnt_q == exec_last) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_POWERUP;
        cnt_d   = '0;
      end
    endcase
  end

  // Output flops are loaded from the next state so they line up with state_q.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_POWERUP;
      cnt_q   <= '0;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
      en_q    <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b1;
      on_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      en_q    <= (state_d == ST_PULSE);
      ready_q <= (state_d == ST_IDLE);
      busy_q  <= (state_d != ST_IDLE);
      on_q    <= lcd_on_en_i;
    end
  end

  assign wr_ready_o = ready_q;
  assign busy_o     = busy_q;
  assign lcd_on_o   = on_q;
  assign lcd_en_o   = en_q;
  assign lcd_rs_o   = rs_q;
  assign lcd_rw_o   = 1'b0;
  assign lcd_data_o = data_q;

endmodule

// File: doc/lcd_char_driver.md
Name: lcd_char_driver

Overview:
- Peripheral end of the CPU's LCD output port: accepts byte-wide command/data writes from the pipeline's LCD I/O register and replays them onto an HD44780-style 8-bit parallel LCD bus.
- Handles power-up settle, the RS/DATA setup window, the EN pulse, hold time and per-command execution delay, so software only has to poll busy.
- Sits between the memory-mapped LCD register and the board LCD pins.

Parameters:
- T_POWERUP, 750000, cycles held busy after reset before the first write is accepted (15 ms at 50 MHz).
- T_SETUP, 2, cycles RS/DATA are stable with EN low before the EN rising edge.
- T_PW, 12, cycles EN is held high.
- T_HOLD, 2, cycles RS/DATA are held after the EN falling edge.
- T_EXEC, 2000, post-write wait for normal commands and data (40 us).
- T_CLEAR, 82000, post-write wait for clear-display/return-home (1.64 ms).
- CNT_W, 20, delay-counter width; must hold the largest T_* value.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous reset, active-high.
- wr_valid_i  in  1  write request from the LCD register.
- wr_ready_o  out  1  driver can accept a write.
- wr_rs_i  in  1  0 = command, 1 = data.
- wr_data_i  in  8  byte to send.
- lcd_on_en_i  in  1  software LCD power/backlight enable.
- busy_o  out  1  inverse of wr_ready_o; readable by software.
- lcd_on_o  out  1  LCD power, registered copy of lcd_on_en_i.
- lcd_en_o  out  1  LCD enable strobe.
- lcd_rs_o  out  1  LCD register select.
- lcd_rw_o  out  1  LCD read/write; tied 0 because the driver is write-only.
- lcd_data_o  out  8  LCD data bus.

Behaviour:
- All outputs are registered.
- Reset values:
  - lcd_en_o = 0, lcd_rs_o = 0, lcd_rw_o = 0, lcd_data_o = 8'h00, lcd_on_o = 0.
  - wr_ready_o = 0, busy_o = 1.
  - FSM state = POWERUP, counter = 0.
- Handshake:
  - A write is accepted on a clock edge where wr_valid_i && wr_ready_o.
  - wr_rs_i/wr_data_i are captured into lcd_rs_o/lcd_data_o on that same edge.
  - wr_ready_o is 1 only in IDLE.
  - wr_valid_i while not ready is ignored; nothing is queued and the requester must hold its request.
- FSM states:
  - POWERUP: count to T_POWERUP-1, then go to IDLE.
  - IDLE: ready=1. On accept, clear the counter and go to SETUP.
  - SETUP: EN=0 for T_SETUP cycles, then go to PULSE.
  - PULSE: EN=1 for T_PW cycles, then go to HOLD.
  - HOLD: EN=0 for T_HOLD cycles, then go to EXEC.
  - EXEC: EN=0 for T_EXEC cycles, or T_CLEAR if the captured write had rs=0 and data in {8'h01, 8'h02, 8'h03}. Then go to IDLE.
- Counter:
  - Clears on every state change and increments otherwise.
  - A state with length N lasts exactly N cycles.
  - A T_* value of 0 is treated as 1.
- Latency:
  - Accept edge to EN rising edge = T_SETUP cycles.
  - Accept edge to next wr_ready_o=1 = T_SETUP+T_PW+T_HOLD+T_EXEC/T_CLEAR cycles.
- lcd_rs_o/lcd_data_o stay stable from the accept edge until the next accept; they do not return to 0 in IDLE.
- lcd_on_o follows lcd_on_en_i with 1 cycle of latency in every state except reset.
- Back-to-back writes: a write presented on the first IDLE cycle is accepted there, so there is no dead cycle between EXEC end and the next accept.
- Reset mid-operation (any state, including PULSE): the next edge forces EN=0, all reset values and POWERUP. The in-flight write is dropped and the full power-up delay is reapplied.
- Counter width: CNT_W must hold max(T_*); the counter must not wrap before the terminal compare.

Test Plan:
1. Overrides: T_POWERUP=10, T_SETUP=2, T_PW=3, T_HOLD=2, T_EXEC=5, T_CLEAR=20. Release rst_i and hold wr_valid_i=1 -> wr_ready_o stays 0 for exactly 10 cycles after release, then goes 1. All LCD outputs stay 0 during that time.
2. Write rs=1, data=8'h41 -> on the accept edge lcd_rs_o=1 and lcd_data_o=8'h41. EN goes high 2 cycles later and stays high 3 cycles. wr_ready_o returns 2+3+2+5 = 12 cycles after accept. lcd_rw_o is 0 throughout.
3. Write rs=0, data=8'h01 -> ready returns 2+3+2+20 = 27 cycles after accept. Write rs=1, data=8'h01 -> ready returns after 12 cycles, since the long delay applies to commands only.
4. Hold wr_valid_i high with 3 different bytes queued by the bench -> exactly 3 EN pulses, each with the correct byte stable for the whole pulse. No write accepted while busy_o=1, and no idle gap cycle between writes.
5. Assert rst_i during PULSE (EN=1) -> EN=0 on the next edge, wr_ready_o=0. The POWERUP delay of 10 cycles is repeated before the next accept.
6. Toggle lcd_on_en_i 0→1→0 during EXEC -> lcd_on_o tracks it with 1 cycle lag, and the FSM timing is unchanged.
